// File: rtl/micros_timer.sv
// Memory-mapped microsecond countdown timer with one-shot and periodic modes.
// Raises a one-cycle irq when the count reaches zero.
//
// state   | meaning
// IDLE    | not counting; COUNT holds its last value
// RUNNING | prescaler running, COUNT decrements once per microsecond tick
module micros_timer #(
  parameter int CLKS_PER_US = 50,
  parameter int PRESC_W     = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        we,
  input  logic [1:0]  addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        irq,
  output logic        busy
);

  typedef enum logic {IDLE, RUNNING} state_t;

  state_t state, state_nxt;

  logic [31:0]        load_q;
  logic [31:0]        count_q;
  logic               periodic_q;
  logic               expired_q;
  logic [PRESC_W-1:0] presc_q;

  logic ctrl_wr;
  logic do_stop;
  logic do_start;
  logic tick;
  logic fire;

  assign ctrl_wr  = we && (addr == 2'd1);
  assign do_stop  = ctrl_wr && wdata[2];
  assign do_start = ctrl_wr && wdata[0] && !wdata[2] && (load_q != 32'd0);
  assign tick     = (state == RUNNING) && (presc_q == PRESC_W'(CLKS_PER_US - 1));
  // A stop or restart on the expiry edge takes priority over the expiry itself.
  assign fire     = tick && (count_q == 32'd1) && !do_stop && !do_start;
  assign busy     = (state == RUNNING);

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (do_start) state_nxt = RUNNING;
      end
      RUNNING: begin
        if (do_stop)                    state_nxt = IDLE;
        else if (do_start)              state_nxt = RUNNING;
        else if (fire && !periodic_q)   state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      load_q     <= 32'd0;
      count_q    <= 32'd0;
      periodic_q <= 1'b0;
      expired_q  <= 1'b0;
      presc_q    <= '0;
      irq        <= 1'b0;
    end else begin
      irq <= fire;

      if (we && (addr == 2'd0)) load_q <= wdata;

      if (do_start) begin
        count_q    <= load_q;
        presc_q    <= '0;
        periodic_q <= wdata[1];
      end else if ((state == RUNNING) && !do_stop) begin
        if (tick) begin
          presc_q <= '0;
          if (count_q == 32'd1) begin
            count_q <= periodic_q ? load_q : 32'd0;
          end else if (count_q != 32'd0) begin
            count_q <= count_q - 32'd1;
          end
        end else begin
          presc_q <= presc_q + PRESC_W'(1);
        end
      end

      if (fire) begin
        expired_q <= 1'b1;
      end else if (we && (addr == 2'd3) && wdata[1]) begin
        expired_q <= 1'b0;
      end
    end
  end

  always_comb begin
    rdata = 32'd0;
    case (addr)
      2'd0: rdata = load_q;
      2'd1: rdata = {30'd0, periodic_q, 1'b0};
      2'd2: rdata = count_q;
      2'd3: rdata = {30'd0, expired_q, busy};
      default: rdata = 32'd0;
    endcase
  end

endmodule

// File: tb/tb_micros_timer.sv
// Directed and randomized bench for micros_timer with a 4-clock microsecond.
// Expected counts and irq times come from arithmetic on start edge and LOAD.
module tb_micros_timer;

  localparam int C = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        we;
  logic [1:0]  addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        irq;
  logic        busy;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int irq_log[$];

  micros_timer #(.CLKS_PER_US(C), .PRESC_W(16)) dut (
    .clk   (clk),
    .reset (reset),
    .we    (we),
    .addr  (addr),
    .wdata (wdata),
    .rdata (rdata),
    .irq   (irq),
    .busy  (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // An irq seen at this negedge was raised by edge number cyc.
  always @(negedge clk) if (irq === 1'b1) irq_log.push_back(cyc);

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, cycle=%0d", cyc);
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Returns the edge number at which the write took effect.
  task automatic wr(input logic [1:0] a, input logic [31:0] d, output int edge_n);
    we = 1'b1; addr = a; wdata = d;
    @(posedge clk); #1;
    we = 1'b0; wdata = 32'd0;
    edge_n = cyc;
  endtask

  task automatic rd(input logic [1:0] a, output logic [31:0] d);
    addr = a;
    #1;
    d = rdata;
  endtask

  task automatic wait_to(input int target);
    while (cyc < target) begin
      @(posedge clk); #1;
    end
  endtask

  function automatic int irq_in(input int lo, input int hi);
    int n = 0;
    foreach (irq_log[i]) if (irq_log[i] >= lo && irq_log[i] <= hi) n++;
    return n;
  endfunction

  function automatic logic [31:0] model_count(input int load, input bit per, input int j);
    int t = j / C;
    if (per) return 32'(load - (t % load));
    return (t >= load) ? 32'd0 : 32'(load - t);
  endfunction

  initial begin
    logic [31:0] v;
    int e0, e, s, load, len, n_exp;
    bit per;

    reset = 1'b1; we = 1'b0; addr = 2'd0; wdata = 32'd0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(posedge clk); #1;
    for (int a = 0; a < 4; a++) begin
      rd(2'(a), v);
      check($sformatf("reset_reg%0d", a), v, 32'd0);
    end
    check("reset_busy", {31'd0, busy}, 32'd0);
    check("reset_irq", {31'd0, irq}, 32'd0);

    // one-shot LOAD=3
    wr(2'd0, 32'd3, e);
    wr(2'd1, 32'h1, e0);
    rd(2'd1, v);
    check("t1_ctrl_read", v, 32'd0);
    wait_to(e0 + 3*C + 6);
    check("t1_irq_at", irq_in(e0 + 3*C, e0 + 3*C), 32'd1);
    check("t1_irq_count", irq_in(e0, cyc), 32'd1);
    check("t1_busy", {31'd0, busy}, 32'd0);
    rd(2'd2, v); check("t1_count", v, 32'd0);
    rd(2'd3, v); check("t1_status", v, 32'h2);
    wr(2'd3, 32'h2, e);
    rd(2'd3, v); check("t1_clear", v, 32'h0);

    // periodic LOAD=2
    wr(2'd0, 32'd2, e);
    wr(2'd1, 32'h3, e0);
    rd(2'd1, v); check("t2_ctrl_read", v, 32'h2);
    for (int j = 0; j <= 26; j++) begin
      wait_to(e0 + j);
      rd(2'd2, v);
      check($sformatf("t2_count_j%0d", j), v, model_count(2, 1'b1, j));
      check($sformatf("t2_busy_j%0d", j), {31'd0, busy}, 32'd1);
    end
    for (int k = 1; k <= 3; k++)
      check($sformatf("t2_irq_k%0d", k), irq_in(e0 + 2*C*k, e0 + 2*C*k), 32'd1);
    check("t2_irq_total", irq_in(e0, e0 + 26), 32'd3);
    wr(2'd1, 32'h4, e);
    wr(2'd3, 32'h2, e);

    // stop mid-count
    wr(2'd0, 32'd5, e);
    wr(2'd1, 32'h1, e0);
    wait_to(e0 + 8);
    wr(2'd1, 32'h4, e);
    check("t3_stop_edge", e - e0, 32'd9);
    check("t3_busy", {31'd0, busy}, 32'd0);
    rd(2'd2, v); check("t3_count", v, 32'd3);
    wait_to(e + 40);
    check("t3_no_irq", irq_in(e0, cyc), 32'd0);

    // start with LOAD=0, then reset mid-count
    wr(2'd0, 32'd0, e);
    wr(2'd1, 32'h1, e0);
    check("t4_busy_load0", {31'd0, busy}, 32'd0);
    wait_to(e0 + 20);
    check("t4_no_irq_load0", irq_in(e0, cyc), 32'd0);
    wr(2'd0, 32'd10, e);
    wr(2'd1, 32'h3, e0);
    wait_to(e0 + 19);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    for (int a = 0; a < 4; a++) begin
      rd(2'(a), v);
      check($sformatf("t4_reset_reg%0d", a), v, 32'd0);
    end
    check("t4_reset_busy", {31'd0, busy}, 32'd0);
    wait_to(e0 + 60);
    check("t4_no_irq_reset", irq_in(e0, cyc), 32'd0);

    // stop on the expiry edge
    wr(2'd0, 32'd1, e);
    wr(2'd1, 32'h1, e0);
    wait_to(e0 + 3);
    wr(2'd1, 32'h4, e);
    check("t5_stop_edge", e - e0, 32'd4);
    rd(2'd3, v); check("t5_status", v, 32'd0);
    rd(2'd2, v); check("t5_count", v, 32'd1);
    wait_to(e0 + 30);
    check("t5_no_irq", irq_in(e0, cyc), 32'd0);

    // LOAD write while periodic running
    wr(2'd0, 32'd2, e);
    wr(2'd1, 32'h3, e0);
    wait_to(e0 + 2);
    wr(2'd0, 32'd4, e);
    rd(2'd2, v); check("t6_count_untouched", v, 32'd2);
    wait_to(e0 + 30);
    check("t6_irq_first", irq_in(e0 + 8, e0 + 8), 32'd1);
    check("t6_irq_second", irq_in(e0 + 24, e0 + 24), 32'd1);
    check("t6_irq_total", irq_in(e0, e0 + 30), 32'd2);
    rd(2'd3, v); check("t6_status", v, 32'h3);
    wr(2'd3, 32'h2, e);
    rd(2'd3, v); check("t6_clear", v, 32'h1);
    wr(2'd1, 32'h4, e);

    // randomized runs against the arithmetic model
    for (int it = 0; it < 8; it++) begin
      load = int'($urandom_range(1, 6));
      per  = bit'($urandom_range(0, 1));
      len  = int'($urandom_range(1, 3*6*C + 5));
      wr(2'd3, 32'h2, e);
      wr(2'd0, 32'(load), e);
      wr(2'd1, per ? 32'h3 : 32'h1, e0);
      for (int j = 0; j <= len; j++) begin
        wait_to(e0 + j);
        rd(2'd2, v);
        check($sformatf("r%0d_count_j%0d", it, j), v, model_count(load, per, j));
        check($sformatf("r%0d_busy_j%0d", it, j), {31'd0, busy},
              {31'd0, per || (j / C < load)});
      end
      wr(2'd1, 32'h4, s);
      rd(2'd2, v);
      check($sformatf("r%0d_frozen", it), v, model_count(load, per, s - 1 - e0));
      wait_to(s + 10);
      n_exp = 0;
      for (int k = 1; e0 + k*load*C < s && (per || k == 1); k++) begin
        check($sformatf("r%0d_irq_k%0d", it, k),
              irq_in(e0 + k*load*C, e0 + k*load*C), 32'd1);
        n_exp++;
      end
      check($sformatf("r%0d_irq_total", it), irq_in(e0 + 1, cyc), 32'(n_exp));
      rd(2'd3, v);
      check($sformatf("r%0d_status", it), v, (n_exp > 0) ? 32'h2 : 32'h0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
